ibex_fetch_req_ctrl: RTL and testbench
======================================

// Module: ibex_fetch_req_ctrl
// PURPOSE
//  Instruction-side bus master between the gated fetch request (instr_req_gated) and the IF/ID stage.
//  Issues word-aligned requests while enabled, tracks outstanding transactions and buffers responses in order.
//  Discards stale responses after a branch and presents {rdata, addr, err} to IF with valid/ready.
//  Its out-side stall condition (ready_i & ~valid_o) is what the core reports as perf_iside_wait.
// PARAMETERS
//  Depth  3  total slots: outstanding requests + buffered responses (>=2); also max outstanding
// PORTS
//  clk_i           in   1   core clock
//  rst_ni          in   1   asynchronous active-low reset
//  req_i           in   1   fetch permitted (gated request from helper)
//  branch_i        in   1   redirect fetch; flushes buffer
//  branch_addr_i   in   32  redirect target (bits [1:0] ignored)
//  ready_i         in   1   IF/ID accepts instruction this cycle
//  valid_o         out  1   rdata_o/addr_o/err_o valid
//  rdata_o         out  32  instruction word
//  addr_o          out  32  address of rdata_o
//  err_o           out  1   bus error for this word
//  instr_req_o     out  1   bus request
//  instr_gnt_i     in   1   bus grant
//  instr_addr_o    out  32  bus address, word aligned
//  instr_rvalid_i  in   1   bus response valid
//  instr_rdata_i   in   32  bus response data
//  instr_err_i     in   1   bus response error
//  busy_o          out  1   outstanding requests or pending request
//  perf_wait_cnt_o out  32  stall-cycle count (0 when feature absent)
// BEHAVIOUR
//  Reset: all outputs 0; fetch_addr_q=0, outstanding=0, discard=0, FIFO empty, FSM IDLE, err_stop=0.
//  No fetch after reset until first branch_i (no boot address here).
//  FSM IDLE: instr_req_o=0; -> REQ when req_i & ~err_stop & (outstanding+count < Depth).
//  FSM REQ: instr_req_o=1, instr_addr_o held stable until gnt (bus rule; no request retraction).
//   On gnt: outstanding++, fetch_addr_q+=4 (wraps mod 2^32); stay REQ if issue cond still true, else IDLE.
//  branch_i in IDLE: fetch_addr_q={branch_addr_i[31:2],2'b00}; request may assert next cycle.
//  branch_i in REQ (no gnt): target latched in pend_addr_q, pend=1; current req completes.
//   Its response is discarded; the next req uses pend_addr_q.
//  branch_i same cycle as gnt: granted request counts as discard; next address = target.
//  Discard: on branch, discard_cnt <= outstanding_next (incl. same-cycle gnt, excl. same-cycle rvalid).
//   rvalid while discard_cnt>0 decrements it and drops data.
//  Responses: rvalid with discard_cnt==0 pushes {err,addr=rsp_addr_q,rdata}; rsp_addr_q+=4.
//   rsp_addr_q loads target on branch.
//  Error: pushed entry with err=1 sets err_stop; no new requests until branch_i clears it.
//  Output: valid_o = ~fifo_empty & ~branch_i; pop on valid_o & ready_i.
//   Push and pop in the same cycle are both allowed.
//  Flush: branch_i empties FIFO same cycle; a same-cycle rvalid is discarded.
//  Capacity invariant: outstanding+count <= Depth, so rvalid never meets a full FIFO.
//   Assert rvalid implies outstanding>0.
//  busy_o = (state==REQ) | (outstanding != 0).
//  req_i low only blocks new requests; a pending REQ still completes, in-flight responses still land.
// CONFIGURATION
//  IBEX_FETCH_PERF_EN defined:
//   perf_wait_cnt_o = 32-bit saturating count of cycles with ready_i & ~valid_o; resets to 0.
//  Not defined: perf_wait_cnt_o tied to 0, no counter flops.
// STRUCTURE
//  ibex_pkg: fetch_entry_t {logic err; logic [31:0] addr; logic [31:0] rdata;}; fetch_state_e {FetchIdle, FetchReq}.
//  Sub-module ibex_fetch_fifo: Depth-entry fetch_entry_t FIFO.
//   Push/pop/flush, count output, flush priority over push.
// TESTING
//  Branch to 0x100, req_i=1, gnt=1 every cycle, rvalid one cycle later -> words 0x100,0x104,0x108 in order.
//  ready_i=0 with Depth=3 -> exactly 3 grants, then instr_req_o=0 until a pop.
//  Branch to 0x200 with 2 outstanding -> both responses dropped; first valid_o carries addr_o=0x200.
//  gnt=0 for 4 cycles, branch to 0x300 mid-wait -> instr_addr_o stable.
//   Old response discarded; next request addr 0x300.
//  rvalid with instr_err_i=1 at 0x40 -> err_o=1 for that word, no further requests until branch_i.
//  IBEX_FETCH_PERF_EN: 10 cycles ready_i=1, valid_o=0 -> perf_wait_cnt_o=10; without macro stays 0.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch request controller.
//   fetch_entry_t : one buffered fetch response {err, addr, rdata}
//   fetch_state_e : request FSM states
//   word_align()  : clear the byte offset of a fetch address
package ibex_pkg;

    localparam int unsigned FetchDepth = 3;
    localparam int unsigned XLen       = 32;

    typedef struct packed {
        logic            err;
        logic [XLen-1:0] addr;
        logic [XLen-1:0] rdata;
    } fetch_entry_t;

    typedef enum logic {
        FetchIdle = 1'b0,
        FetchReq  = 1'b1
    } fetch_state_e;

    function automatic logic [XLen-1:0] word_align(input logic [XLen-1:0] a);
        return {a[XLen-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_fetch_fifo.sv
// In-order response buffer for the fetch controller.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empty the buffer (wins over push_i)
//   push_i/data_i : write one entry
//   pop_i         : drop the head entry
//   data_o        : head entry (valid when empty_o == 0)
//   empty_o       : buffer empty
//   count_o       : number of stored entries
module ibex_fetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = FetchDepth,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = ($clog2(Depth) > 0) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    data_i,
    input  logic            pop_i,
    output fetch_entry_t    data_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;
    logic            full;

    // Pointers wrap explicitly because Depth need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-side bus master feeding the IF/ID stage.
// Issues word-aligned requests while permitted, tracks outstanding bus
// transactions, drops responses made stale by a branch and buffers the
// rest in order for IF (valid_o/ready_i handshake).
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_i, branch_i, branch_addr_i     fetch permission and redirect
//   ready_i, valid_o, rdata_o, addr_o, err_o   IF/ID side
//   instr_req_o, instr_gnt_i, instr_addr_o     bus request channel
//   instr_rvalid_i, instr_rdata_i, instr_err_i bus response channel
//   busy_o                             request pending or in flight
//   perf_wait_cnt_o                    IF stall-cycle counter
// Optional feature macro: IBEX_FETCH_PERF_EN enables the saturating
// stall counter on perf_wait_cnt_o; otherwise it is tied to zero.
module ibex_fetch_req_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = FetchDepth
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic [31:0] perf_wait_cnt_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned SumW = CntW + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     pend_addr_q, pend_addr_d;
    logic            pend_q, pend_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [31:0]     rsp_addr_q, rsp_addr_d;
    logic            err_stop_q, err_stop_d;
    logic            fetch_en_q, fetch_en_d;

    logic [31:0]     target;
    logic            gnt_acc;
    logic            rsp_drop;
    logic            push_c;
    logic            push_ok;
    logic            pop;
    logic            issue_ok;
    logic [CntW-1:0] count_d;
    logic [SumW-1:0] slots_d;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    assign target     = word_align(branch_addr_i);
    assign gnt_acc    = (state_q == FetchReq) & instr_gnt_i;
    assign rsp_drop   = (discard_q != '0);
    assign push_c     = instr_rvalid_i & ~rsp_drop;
    assign push_ok    = push_c & ~branch_i;
    assign valid_o    = ~fifo_empty & ~branch_i;
    assign pop        = valid_o & ready_i;
    assign push_entry = '{err: instr_err_i, addr: rsp_addr_q, rdata: instr_rdata_i};

    assign rdata_o      = head_entry.rdata;
    assign addr_o       = head_entry.addr;
    assign err_o        = head_entry.err;
    assign instr_req_o  = (state_q == FetchReq);
    assign instr_addr_o = fetch_addr_q;
    assign busy_o       = instr_req_o | (outstanding_q != '0);

    ibex_fetch_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (branch_i),
        .push_i  (push_c),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bookkeeping: occupancy, stale-response tracking, error stop, response address.
    always_comb begin
        outstanding_d = outstanding_q + CntW'(gnt_acc) - CntW'(instr_rvalid_i);
        count_d       = branch_i ? '0 : fifo_count + CntW'(push_ok) - CntW'(pop);
        slots_d       = SumW'(outstanding_d) + SumW'(count_d);
        fetch_en_d    = fetch_en_q | branch_i;

        err_stop_d = err_stop_q;
        if (branch_i) begin
            err_stop_d = 1'b0;
        end else if (push_ok & instr_err_i) begin
            err_stop_d = 1'b1;
        end

        issue_ok = fetch_en_d & req_i & ~err_stop_d & (slots_d < SumW'(Depth));

        // A request granted while a redirect is pending fetched the old stream.
        discard_d = discard_q;
        if (instr_rvalid_i & rsp_drop) begin
            discard_d = discard_d - CntW'(1);
        end
        if (gnt_acc & pend_q) begin
            discard_d = discard_d + CntW'(1);
        end
        if (branch_i) begin
            discard_d = outstanding_d;
        end

        rsp_addr_d = rsp_addr_q;
        if (branch_i) begin
            rsp_addr_d = target;
        end else if (push_ok) begin
            rsp_addr_d = rsp_addr_q + 32'd4;
        end
    end

    // Request FSM: next state and next fetch address.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;

        unique case (state_q)
            FetchIdle: begin
                if (branch_i) begin
                    fetch_addr_d = target;
                end
                if (issue_ok) begin
                    state_d = FetchReq;
                end
            end
            FetchReq: begin
                if (gnt_acc) begin
                    pend_d = 1'b0;
                    if (branch_i) begin
                        fetch_addr_d = target;
                    end else if (pend_q) begin
                        fetch_addr_d = pend_addr_q;
                    end else begin
                        fetch_addr_d = fetch_addr_q + 32'd4;
                    end
                    state_d = issue_ok ? FetchReq : FetchIdle;
                end else if (branch_i) begin
                    // Address must stay stable until grant; remember the redirect.
                    pend_d      = 1'b1;
                    pend_addr_d = target;
                end
            end
            default: state_d = FetchIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FetchIdle;
            fetch_addr_q  <= '0;
            pend_addr_q   <= '0;
            pend_q        <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rsp_addr_q    <= '0;
            err_stop_q    <= 1'b0;
            fetch_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pend_addr_q   <= pend_addr_d;
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rsp_addr_q    <= rsp_addr_d;
            err_stop_q    <= err_stop_d;
            fetch_en_q    <= fetch_en_d;
        end
    end

`ifdef IBEX_FETCH_PERF_EN
    logic [31:0] perf_wait_q;

    // Saturating count of cycles where IF is ready but has nothing to take.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_wait_q <= '0;
        end else if (ready_i & ~valid_o & (perf_wait_q != '1)) begin
            perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_wait_cnt_o = perf_wait_q;
`else
    assign perf_wait_cnt_o = '0;
`endif

    // Every response must belong to a granted request.
    rvalid_has_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scoreboard bench for ibex_fetch_req_ctrl: a bus model answers every grant
// one cycle later; responses belonging to the live fetch stream are queued
// as expected IF words and compared when IF pops them.
module tb_ibex_fetch_req_ctrl;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;
    logic [31:0] perf_wait_cnt_o;

    ibex_fetch_req_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .branch_i        (branch_i),
        .branch_addr_i   (branch_addr_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .addr_o          (addr_o),
        .err_o           (err_o),
        .instr_req_o     (instr_req_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_addr_o    (instr_addr_o),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_i     (instr_err_i),
        .busy_o          (busy_o),
        .perf_wait_cnt_o (perf_wait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        fresh;
        int unsigned epoch;
    } bus_txn_t;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  grants = 0;
    int unsigned  epoch  = 0;
    logic [31:0]  stream_next = '0;
    logic [31:0]  err_addr = 32'hFFFF_FFFC;
    logic         req_k, ready_k, gnt_k, rsp_en;
    bus_txn_t     rsp_q[$];
    fetch_entry_t sb[$];
    fetch_entry_t pop_log[$];
    logic [31:0]  gnt_log[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F00;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, update the model.
    task automatic run_cycle(input logic br, input logic [31:0] br_addr);
        bus_txn_t     cur;
        logic         have;
        fetch_entry_t exp;
        @(negedge clk_i);
        branch_i      = br;
        branch_addr_i = br_addr;
        req_i         = req_k;
        ready_i       = ready_k;
        instr_gnt_i   = gnt_k;
        have          = rsp_en && (rsp_q.size() > 0);
        if (have) begin
            cur            = rsp_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(cur.addr);
            instr_err_i    = (cur.addr == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
        #1;
        if (br) begin
            epoch++;
            stream_next = {br_addr[31:2], 2'b00};
            sb.delete();
        end
        if (valid_o && ready_i) begin
            pop_log.push_back('{err: err_o, addr: addr_o, rdata: rdata_o});
            if (sb.size() == 0) begin
                check_val("pop_with_empty_scoreboard", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check_val("pop_addr", addr_o, exp.addr);
                check_val("pop_rdata", rdata_o, exp.rdata);
                check_val("pop_err", 32'(err_o), 32'(exp.err));
            end
        end
        if (have && cur.fresh && (cur.epoch == epoch)) begin
            sb.push_back('{err: (cur.addr == err_addr), addr: cur.addr, rdata: mem_word(cur.addr)});
        end
        if (instr_req_o && instr_gnt_i) begin
            grants++;
            gnt_log.push_back(instr_addr_o);
            cur.addr  = instr_addr_o;
            cur.fresh = (instr_addr_o == stream_next);
            cur.epoch = epoch;
            if (cur.fresh) stream_next = stream_next + 32'd4;
            rsp_q.push_back(cur);
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0);
    endtask

    // Stop fetching and let every in-flight word reach IF.
    task automatic drain(input string tag);
        logic done;
        req_k = 1'b0; ready_k = 1'b1; gnt_k = 1'b1; rsp_en = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            run_cycle(1'b0, 32'h0);
            done = !busy_o && !valid_o && (rsp_q.size() == 0);
        end
        check_val({tag, "_drain_done"}, 32'(done), 32'd1);
        check_val({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int unsigned g0;
        logic [31:0] p0;

        rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; instr_err_i = 1'b0;
        req_k = 1'b0; ready_k = 1'b0; gnt_k = 1'b0; rsp_en = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_instr_req", 32'(instr_req_o), 32'd0);
        check_val("rst_instr_addr", instr_addr_o, 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_rdata", rdata_o, 32'd0);
        check_val("rst_addr", addr_o, 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_perf", perf_wait_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // No fetch before the first redirect.
        req_k = 1'b1; gnt_k = 1'b1; rsp_en = 1'b1;
        run_n(5);
        check_val("boot_no_grant", 32'(grants), 32'd0);
        check_val("boot_no_req", 32'(instr_req_o), 32'd0);

        // Streaming from 0x100.
        ready_k = 1'b1;
        pop_log.delete();
        run_cycle(1'b1, 32'h100);
        run_n(10);
        check_val("t1_pop_count_ge3", 32'(pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            check_val("t1_word0_addr", pop_log[0].addr, 32'h100);
            check_val("t1_word1_addr", pop_log[1].addr, 32'h104);
            check_val("t1_word2_addr", pop_log[2].addr, 32'h108);
        end
        drain("t1");
        check_val("t1_idle_busy", 32'(busy_o), 32'd0);

        // IF stalled: capacity limits grants to Depth.
        req_k = 1'b1; ready_k = 1'b0; gnt_k = 1'b1; rsp_en = 1'b1;
        g0 = grants;
        run_cycle(1'b1, 32'h403);
        run_n(15);
        check_val("t2_grants_full", grants - g0, 32'd3);
        check_val("t2_req_low_full", 32'(instr_req_o), 32'd0);
        check_val("t2_valid_full", 32'(valid_o), 32'd1);
        ready_k = 1'b1;
        run_n(1);
        ready_k = 1'b0;
        run_n(6);
        check_val("t2_grants_after_pop", grants - g0, 32'd4);
        check_val("t2_req_low_again", 32'(instr_req_o), 32'd0);
        drain("t2");

        // Redirect with two requests in flight.
        req_k = 1'b1; ready_k = 1'b1; gnt_k = 1'b1; rsp_en = 1'b0;
        g0 = grants;
        run_cycle(1'b1, 32'h180);
        for (int i = 0; i < 10 && (grants - g0) < 2; i++) run_cycle(1'b0, 32'h0);
        check_val("t3_two_outstanding", 32'((grants - g0) >= 2), 32'd1);
        rsp_en = 1'b1;
        pop_log.delete();
        run_cycle(1'b1, 32'h200);
        run_n(10);
        check_val("t3_pop_seen", 32'(pop_log.size() > 0), 32'd1);
        if (pop_log.size() > 0) check_val("t3_first_addr", pop_log[0].addr, 32'h200);
        drain("t3");

        // Grant stall with a redirect mid-wait.
        req_k = 1'b1; ready_k = 1'b1; gnt_k = 1'b0; rsp_en = 1'b1;
        run_cycle(1'b1, 32'h280);
        for (int i = 0; i < 4; i++) begin
            run_cycle(i == 1, 32'h300);
            check_val("t4_req_held", 32'(instr_req_o), 32'd1);
            check_val("t4_addr_stable", instr_addr_o, 32'h280);
        end
        check_val("t4_busy", 32'(busy_o), 32'd1);
        gnt_k = 1'b1;
        gnt_log.delete();
        pop_log.delete();
        run_n(8);
        check_val("t4_gnt_count_ge2", 32'(gnt_log.size() >= 2), 32'd1);
        if (gnt_log.size() >= 2) begin
            check_val("t4_stale_gnt_addr", gnt_log[0], 32'h280);
            check_val("t4_next_req_addr", gnt_log[1], 32'h300);
        end
        if (pop_log.size() > 0) check_val("t4_first_addr", pop_log[0].addr, 32'h300);
        else check_val("t4_pop_seen", 32'(pop_log.size()), 32'd1);
        drain("t4");

        // Bus error stops fetching until the next redirect.
        req_k = 1'b1; ready_k = 1'b1; gnt_k = 1'b1; rsp_en = 1'b1;
        err_addr = 32'h40;
        pop_log.delete();
        run_cycle(1'b1, 32'h38);
        run_n(12);
        begin
            logic seen;
            seen = 1'b0;
            foreach (pop_log[i]) begin
                if (pop_log[i].addr == 32'h40) begin
                    seen = 1'b1;
                    check_val("t5_err_word", 32'(pop_log[i].err), 32'd1);
                end
                if (pop_log[i].addr == 32'h38) check_val("t5_ok_word", 32'(pop_log[i].err), 32'd0);
            end
            check_val("t5_err_word_seen", 32'(seen), 32'd1);
        end
        g0 = grants;
        run_n(8);
        check_val("t5_no_grants_after_err", grants - g0, 32'd0);
        check_val("t5_req_low", 32'(instr_req_o), 32'd0);
        err_addr = 32'hFFFF_FFFC;
        run_cycle(1'b1, 32'h600);
        run_n(3);
        check_val("t5_resume_after_branch", 32'(grants > g0), 32'd1);
        drain("t5");

        // Stall-cycle counter.
        ready_k = 1'b0;
        run_n(2);
        p0 = perf_wait_cnt_o;
        ready_k = 1'b1;
        run_n(10);
        ready_k = 1'b0;
        run_n(1);
`ifdef IBEX_FETCH_PERF_EN
        check_val("perf_wait_delta", perf_wait_cnt_o - p0, 32'd10);
`else
        check_val("perf_wait_tied", perf_wait_cnt_o, 32'd0);
        check_val("perf_wait_base", p0, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
